// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_filt_pkg.sv
// Shared definitions for the glitch-filtered and4 qualifier family.
// State encoding is Gray-ordered so that Q is simply the state MSB.
package gf180mcu_fd_sc_mcu7t5v0__and4_filt_pkg;

    // Number of match inputs (A1..A4), treated as independent lanes.
    localparam int NUM_LANES = 4;

    // Width of the run-length counter; bounds both ON_LEN and OFF_LEN.
    localparam int CNT_W = 4;

    // IDLE/ARM hold Q low, ON/DISARM hold Q high: Q == state[1].
    typedef enum logic [1:0] {
        st_idle   = 2'b00,
        st_arm    = 2'b01,
        st_on     = 2'b11,
        st_disarm = 2'b10
    } filt_state_e;

    // Legal range for a filter length so the counter can never wrap.
    function automatic bit len_ok(input int n);
        return (n >= 1) && (n <= (1 << CNT_W) - 1);
    endfunction

    // Legal synchronizer depth.
    function automatic bit sync_ok(input int n);
        return (n >= 1) && (n <= 3);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_filt_func.sv
// Functional core: synchronize A1..A4, AND them into ms, then run a
// hysteresis filter that asserts Q after ON_LEN matched samples and
// releases it after OFF_LEN unmatched samples.
module gf180mcu_fd_sc_mcu7t5v0__and4_filt_func
    import gf180mcu_fd_sc_mcu7t5v0__and4_filt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ON_LEN      = 3,
    parameter int OFF_LEN     = 2
) (
`ifdef USE_POWER_PINS
    inout wire  VDD,
    inout wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic E,
    output logic Q,
    output logic EVT
);

    // Reject parameters that could overflow the counter or the sync chain.
    generate
        if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
            $error("and4_filt: SYNC_STAGES must be 1..3");
        end
        if (!len_ok(ON_LEN)) begin : g_bad_on
            $error("and4_filt: ON_LEN must be 1..15");
        end
        if (!len_ok(OFF_LEN)) begin : g_bad_off
            $error("and4_filt: OFF_LEN must be 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] on_len_c  = CNT_W'(ON_LEN);
    localparam logic [CNT_W-1:0] off_len_c = CNT_W'(OFF_LEN);
    localparam logic [CNT_W-1:0] one_c     = CNT_W'(1);

    logic [NUM_LANES-1:0] a_raw;
    logic [NUM_LANES-1:0] a_sync;
    logic                 ms;

    assign a_raw = {A4, A3, A2, A1};

    // One synchronizer per input lane; the sync chain runs regardless of E.
    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            gf180mcu_fd_sc_mcu7t5v0__and4_filt_sync #(
                .STAGES(SYNC_STAGES)
            ) u_sync (
`ifdef USE_POWER_PINS
                .VDD (VDD),
                .VSS (VSS),
`endif
                .CLK (CLK),
                .RN  (RN),
                .d   (a_raw[l]),
                .q   (a_sync[l])
            );
        end
    endgenerate

    // Match term comes from the library and4 function so the filter tracks it exactly.
    gf180mcu_fd_sc_mcu7t5v0__and4_func u_and4 (
`ifdef USE_POWER_PINS
        .VDD (VDD),
        .VSS (VSS),
`endif
        .A1  (a_sync[0]),
        .A2  (a_sync[1]),
        .A3  (a_sync[2]),
        .A4  (a_sync[3]),
        .Z   (ms)
    );

    filt_state_e      st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             evt_q;

    assign cnt_inc = cnt + one_c;

    // Hysteresis FSM; E=0 freezes state/cnt and suppresses EVT.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            st    <= st_idle;
            cnt   <= '0;
            evt_q <= 1'b0;
        end else if (!E) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (st)
                st_idle: begin
                    if (ms) begin
                        if (ON_LEN == 1) begin
                            st    <= st_on;
                            cnt   <= '0;
                            evt_q <= 1'b1;
                        end else begin
                            st  <= st_arm;
                            cnt <= one_c;
                        end
                    end
                end
                st_arm: begin
                    if (!ms) begin
                        // Any dropout throws away the partial count.
                        st  <= st_idle;
                        cnt <= '0;
                    end else if (cnt_inc == on_len_c) begin
                        st    <= st_on;
                        cnt   <= '0;
                        evt_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                st_on: begin
                    if (!ms) begin
                        if (OFF_LEN == 1) begin
                            st  <= st_idle;
                            cnt <= '0;
                        end else begin
                            st  <= st_disarm;
                            cnt <= one_c;
                        end
                    end
                end
                st_disarm: begin
                    if (ms) begin
                        // Match came back before release: stay on, no new event.
                        st  <= st_on;
                        cnt <= '0;
                    end else if (cnt_inc == off_len_c) begin
                        st  <= st_idle;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    st  <= st_idle;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Gray encoding makes the state MSB the registered Q flag.
    assign Q   = st[1];
    assign EVT = evt_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_filt_sync.sv
// Per-bit synchronizer: STAGES flops in series, asynchronously cleared.
module gf180mcu_fd_sc_mcu7t5v0__and4_filt_sync #(
    parameter int STAGES = 2
) (
`ifdef USE_POWER_PINS
    inout wire  VDD,
    inout wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_pipe;

    // Shift the raw input through the chain; reset clears every stage.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_func.sv
// Functional and4: Z is high only when all four inputs are high.
module gf180mcu_fd_sc_mcu7t5v0__and4_func (
`ifdef USE_POWER_PINS
    inout wire  VDD,
    inout wire  VSS,
`endif
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    output logic Z
);

    assign Z = A1 & A2 & A3 & A4;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_filt_2.sv
// Drive-2 and4 glitch-filter cell: wraps the functional core and carries
// nominal timing arcs until the cell is characterized.
module gf180mcu_fd_sc_mcu7t5v0__and4_filt_2 #(
    parameter int SYNC_STAGES = 2,
    parameter int ON_LEN      = 3,
    parameter int OFF_LEN     = 2
) (
`ifdef USE_POWER_PINS
    inout wire  VDD,
    inout wire  VSS,
`endif
    input  logic CLK,
    input  logic RN,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic E,
    output logic Q,
    output logic EVT
);

    gf180mcu_fd_sc_mcu7t5v0__and4_filt_func #(
        .SYNC_STAGES (SYNC_STAGES),
        .ON_LEN      (ON_LEN),
        .OFF_LEN     (OFF_LEN)
    ) u_func (
`ifdef USE_POWER_PINS
        .VDD (VDD),
        .VSS (VSS),
`endif
        .CLK (CLK),
        .RN  (RN),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .A4  (A4),
        .E   (E),
        .Q   (Q),
        .EVT (EVT)
    );

`ifndef FUNCTIONAL
    specify
        (posedge CLK => (Q +: 1'b1))   = (1.0, 1.0);
        (posedge CLK => (EVT +: 1'b1)) = (1.0, 1.0);
        (negedge RN => (Q +: 1'b0))    = (1.0, 1.0);
        (negedge RN => (EVT +: 1'b0))  = (1.0, 1.0);
        $setuphold(posedge CLK, A1, 1.0, 1.0);
        $setuphold(posedge CLK, A2, 1.0, 1.0);
        $setuphold(posedge CLK, A3, 1.0, 1.0);
        $setuphold(posedge CLK, A4, 1.0, 1.0);
        $setuphold(posedge CLK, E, 1.0, 1.0);
        $recrem(posedge RN, posedge CLK, 1.0, 1.0);
    endspecify
`endif

endmodule
